// File: rtl/anim_pkg.sv
// Shared types and constants for the animation front-end: speed code range
// and the Q1.2 fractional width used by the offset accumulator.
package anim_pkg;

  typedef logic [2:0] speed_t;

  localparam speed_t SPEED_MIN   = 3'd1;
  localparam speed_t SPEED_MAX   = 3'd6;
  localparam speed_t SPEED_RESET = 3'd1;

  localparam int FRAC_BITS = 2;

  // Opposing requests in the same cycle cancel; otherwise step once and saturate.
  function automatic speed_t next_speed(input speed_t cur, input logic faster, input logic slower);
    speed_t nxt;
    nxt = cur;
    if (faster && !slower && (cur < SPEED_MAX)) begin
      nxt = cur + 3'd1;
    end else if (slower && !faster && (cur > SPEED_MIN)) begin
      nxt = cur - 3'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus stability counter for one raw button; emits a
// single-cycle press event on each accepted 0->1 change of the debounced level.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // Any disagreement that does not persist for the full window restarts the count.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
      press_d = sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/animation_sequencer.sv
// Button front-end for speed_controller and per-frame offset accumulator:
// turns debounced presses into speed/pause/resume, advances offset on vsync.
module animation_sequencer
  import anim_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int OFFSET_WIDTH    = 10,
  parameter int OFFSET_PERIOD   = 640
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    btn_pause,
  input  logic                    btn_faster,
  input  logic                    btn_slower,
  input  logic                    vsync,
  input  logic [2:0]              step_size,
  input  logic                    paused,
  output logic [2:0]              speed,
  output logic                    pause,
  output logic                    resume,
  output logic                    frame_tick,
  output logic [OFFSET_WIDTH-1:0] offset,
  output logic [FRAC_BITS-1:0]    offset_frac
);

  localparam int INT_W = OFFSET_WIDTH + 1;
  localparam int ACC_W = INT_W + FRAC_BITS;
  localparam logic [INT_W-1:0] PERIOD_EXT = INT_W'(OFFSET_PERIOD);

  logic pause_evt, faster_evt, slower_evt;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause_db (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_pause),
    .press   (pause_evt)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_faster_db (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_faster),
    .press   (faster_evt)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_slower_db (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_slower),
    .press   (slower_evt)
  );

  logic                    vs_meta_q,  vs_meta_d;
  logic                    vs_sync_q,  vs_sync_d;
  logic                    vs_prev_q,  vs_prev_d;
  speed_t                  speed_q,    speed_d;
  logic                    pause_q,    pause_d;
  logic                    resume_q,   resume_d;
  logic                    tick_q,     tick_d;
  logic [OFFSET_WIDTH-1:0] offset_q,   offset_d;
  logic [FRAC_BITS-1:0]    frac_q,     frac_d;

  logic                    vsync_rise;
  logic [ACC_W-1:0]        acc_sum;
  logic [INT_W-1:0]        sum_int;

  assign vsync_rise = vs_sync_q & ~vs_prev_q;
  assign acc_sum    = {1'b0, offset_q, frac_q} + {{(ACC_W-3){1'b0}}, step_size};
  assign sum_int    = acc_sum[ACC_W-1:FRAC_BITS];

  // Step is at most 1.5 px, so a single conditional subtract keeps the offset in range.
  always_comb begin
    vs_meta_d = vsync;
    vs_sync_d = vs_meta_q;
    vs_prev_d = vs_sync_q;
    speed_d   = next_speed(speed_q, faster_evt, slower_evt);
    pause_d   = pause_evt & ~paused;
    resume_d  = pause_evt & paused;
    tick_d    = 1'b0;
    offset_d  = offset_q;
    frac_d    = frac_q;
    if (vsync_rise && !paused) begin
      tick_d = 1'b1;
      frac_d = acc_sum[FRAC_BITS-1:0];
      if (sum_int >= PERIOD_EXT) begin
        offset_d = OFFSET_WIDTH'(sum_int - PERIOD_EXT);
      end else begin
        offset_d = OFFSET_WIDTH'(sum_int);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_meta_q <= 1'b0;
      vs_sync_q <= 1'b0;
      vs_prev_q <= 1'b0;
      speed_q   <= SPEED_RESET;
      pause_q   <= 1'b0;
      resume_q  <= 1'b0;
      tick_q    <= 1'b0;
      offset_q  <= '0;
      frac_q    <= '0;
    end else begin
      vs_meta_q <= vs_meta_d;
      vs_sync_q <= vs_sync_d;
      vs_prev_q <= vs_prev_d;
      speed_q   <= speed_d;
      pause_q   <= pause_d;
      resume_q  <= resume_d;
      tick_q    <= tick_d;
      offset_q  <= offset_d;
      frac_q    <= frac_d;
    end
  end

  assign speed       = speed_q;
  assign pause       = pause_q;
  assign resume      = resume_q;
  assign frame_tick  = tick_q;
  assign offset      = offset_q;
  assign offset_frac = frac_q;

endmodule

// File: tb/tb_animation_sequencer.sv
// Self-checking bench for animation_sequencer with a behavioural
// speed_controller in the loop and a modular-arithmetic position model.
module tb_animation_sequencer;

  localparam int PERIOD_Q = 640 * 4;

  logic       clk;
  logic       rst;
  logic       btn_pause, btn_faster, btn_slower;
  logic       vsync;
  logic [2:0] step_size;
  logic       paused;
  logic [2:0] speed;
  logic       pause, resume, frame_tick;
  logic [9:0] offset;
  logic [1:0] offset_frac;

  bit         force_en;
  logic [2:0] force_step;

  int checks = 0;
  int failures = 0;
  int pause_cnt = 0, resume_cnt = 0, tick_cnt = 0;
  int overlap_cnt = 0, range_err = 0;

  int ref_pos = 0;
  int ref_speed = 1;
  bit ref_paused = 0;

  animation_sequencer #(
    .DEBOUNCE_CYCLES (4),
    .OFFSET_WIDTH    (10),
    .OFFSET_PERIOD   (640)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_pause   (btn_pause),
    .btn_faster  (btn_faster),
    .btn_slower  (btn_slower),
    .vsync       (vsync),
    .step_size   (step_size),
    .paused      (paused),
    .speed       (speed),
    .pause       (pause),
    .resume      (resume),
    .frame_tick  (frame_tick),
    .offset      (offset),
    .offset_frac (offset_frac)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for speed_controller: step equals the speed code in Q1.2, paused is registered.
  assign step_size = force_en ? force_step : speed;

  always @(posedge clk or posedge rst) begin
    if (rst) paused <= 1'b0;
    else if (pause) paused <= 1'b1;
    else if (resume) paused <= 1'b0;
  end

  always @(negedge clk) begin
    if (pause) pause_cnt++;
    if (resume) resume_cnt++;
    if (frame_tick) tick_cnt++;
    if (pause && resume) overlap_cnt++;
    if (!rst && (speed < 3'd1 || speed > 3'd6)) range_err++;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sendVsync(input string tag);
    int ticks0;
    int step;
    ticks0 = tick_cnt;
    step = force_en ? int'(force_step) : ref_speed;
    if (!ref_paused) ref_pos = (ref_pos + step) % PERIOD_Q;
    vsync = 1'b1;
    waitCycles(3);
    vsync = 1'b0;
    waitCycles(4);
    #1;
    checkOutput({tag, ":ticks"}, tick_cnt - ticks0, ref_paused ? 0 : 1);
    checkOutput({tag, ":offset"}, int'(offset), ref_pos / 4);
    checkOutput({tag, ":frac"}, int'(offset_frac), ref_pos % 4);
  endtask

  task automatic applyStimulus(input string tag, input bit p, input bit f, input bit s);
    int p0, r0, exp_p, exp_r;
    p0 = pause_cnt;
    r0 = resume_cnt;
    exp_p = 0;
    exp_r = 0;
    btn_pause = p;
    btn_faster = f;
    btn_slower = s;
    waitCycles(10);
    btn_pause = 1'b0;
    btn_faster = 1'b0;
    btn_slower = 1'b0;
    waitCycles(12);
    #1;
    if (f && !s && ref_speed < 6) ref_speed++;
    else if (s && !f && ref_speed > 1) ref_speed--;
    if (p) begin
      if (ref_paused) exp_r = 1;
      else exp_p = 1;
      ref_paused = !ref_paused;
    end
    checkOutput({tag, ":speed"}, int'(speed), ref_speed);
    checkOutput({tag, ":pauses"}, pause_cnt - p0, exp_p);
    checkOutput({tag, ":resumes"}, resume_cnt - r0, exp_r);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ":speed"}, int'(speed), 1);
    checkOutput({tag, ":pause"}, int'(pause), 0);
    checkOutput({tag, ":resume"}, int'(resume), 0);
    checkOutput({tag, ":tick"}, int'(frame_tick), 0);
    checkOutput({tag, ":offset"}, int'(offset), 0);
    checkOutput({tag, ":frac"}, int'(offset_frac), 0);
  endtask

  initial begin
    int remaining;
    int p0, r0, r;
    rst = 1'b1;
    btn_pause = 1'b0;
    btn_faster = 1'b0;
    btn_slower = 1'b0;
    vsync = 1'b0;
    force_en = 1'b0;
    force_step = 3'd0;

    waitCycles(3);
    #1;
    checkResetValues("reset");
    @(negedge clk);
    rst = 1'b0;
    waitCycles(3);

    for (int i = 0; i < 4; i++) sendVsync("speed1Frame");

    // Random fractional steps walk the position up to exactly 639.75.
    force_en = 1'b1;
    remaining = (PERIOD_Q - 1) - ref_pos;
    while (remaining > 6) begin
      force_step = 3'($urandom_range(1, 6));
      sendVsync("climb");
      remaining = (PERIOD_Q - 1) - ref_pos;
    end
    if (remaining > 0) begin
      force_step = 3'(remaining);
      sendVsync("climbLast");
    end
    checkOutput("at639:offset", int'(offset), 639);
    checkOutput("at639:frac", int'(offset_frac), 3);
    force_step = 3'd6;
    sendVsync("wrap");
    checkOutput("wrap:offset", int'(offset), 1);
    checkOutput("wrap:frac", int'(offset_frac), 1);
    force_en = 1'b0;

    for (int i = 0; i < 7; i++) applyStimulus("faster", 1'b0, 1'b1, 1'b0);
    checkOutput("fasterSat", int'(speed), 6);
    for (int i = 0; i < 7; i++) applyStimulus("slower", 1'b0, 1'b0, 1'b1);
    checkOutput("slowerSat", int'(speed), 1);
    applyStimulus("faster", 1'b0, 1'b1, 1'b0);
    applyStimulus("both", 1'b0, 1'b1, 1'b1);
    checkOutput("bothUnchanged", int'(speed), 2);

    p0 = pause_cnt;
    r0 = resume_cnt;
    btn_pause = 1'b1; waitCycles(1);
    btn_pause = 1'b0; waitCycles(1);
    btn_pause = 1'b1; waitCycles(10);
    btn_pause = 1'b0; waitCycles(12);
    #1;
    ref_paused = 1'b1;
    checkOutput("bounce:pauses", pause_cnt - p0, 1);
    checkOutput("bounce:resumes", resume_cnt - r0, 0);
    sendVsync("frozen");
    sendVsync("frozen");
    applyStimulus("resumePress", 1'b1, 1'b0, 1'b0);
    sendVsync("resumed");

    p0 = pause_cnt;
    r0 = resume_cnt;
    btn_pause = 1'b1; waitCycles(3);
    btn_pause = 1'b0; waitCycles(12);
    #1;
    checkOutput("glitch:pauses", pause_cnt - p0, 0);
    checkOutput("glitch:resumes", resume_cnt - r0, 0);

    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 4));
      case (r)
        0: applyStimulus("rndFaster", 1'b0, 1'b1, 1'b0);
        1: applyStimulus("rndSlower", 1'b0, 1'b0, 1'b1);
        2: applyStimulus("rndPause", 1'b1, 1'b0, 1'b0);
        default: sendVsync("rndVsync");
      endcase
    end

    if (ref_paused) applyStimulus("unpause", 1'b1, 1'b0, 1'b0);
    force_en = 1'b1;
    force_step = 3'd6;
    sendVsync("preReset");
    sendVsync("preReset");
    force_en = 1'b0;

    // Reset lands between edges while a faster press is mid-debounce.
    btn_faster = 1'b1;
    waitCycles(3);
    #3;
    rst = 1'b1;
    #1;
    checkResetValues("midReset");
    ref_pos = 0;
    ref_speed = 1;
    ref_paused = 1'b0;
    waitCycles(2);
    rst = 1'b0;
    p0 = pause_cnt;
    waitCycles(3);
    #1;
    checkOutput("heldEarly:speed", int'(speed), 1);
    waitCycles(12);
    #1;
    checkOutput("heldPress:speed", int'(speed), 2);
    waitCycles(20);
    #1;
    checkOutput("heldOnce:speed", int'(speed), 2);
    checkOutput("heldOnce:pauses", pause_cnt - p0, 0);
    btn_faster = 1'b0;
    waitCycles(12);

    checkOutput("pauseResumeOverlap", overlap_cnt, 0);
    checkOutput("speedRange", range_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/animation_sequencer.md
Name: animation_sequencer

Overview:
Front-end controller for `speed_controller`. It turns raw board buttons into the `speed` code and the `pause`/`resume` pulses that configure it. It then uses the returned `step_size` (Q1.2) and `paused` state to advance the per-frame pattern offset on each vsync rising edge. It sits between the input pins, `speed_controller` and the pattern generators, and is the single source of `frame_tick` and the animation offset.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive stable clk cycles needed to accept a button level change (10 ms at 25 MHz).
- OFFSET_WIDTH, 10, integer width of the offset accumulator.
- OFFSET_PERIOD, 640, offset wrap modulus; must satisfy 2 <= OFFSET_PERIOD <= 2^OFFSET_WIDTH.

Ports:
- clk, in, 1: pixel clock.
- rst, in, 1: reset, asynchronous, active-high.
- btn_pause, in, 1: async raw button; press toggles pause.
- btn_faster, in, 1: async raw button; press increments speed.
- btn_slower, in, 1: async raw button; press decrements speed.
- vsync, in, 1: async vertical sync, active-high.
- step_size, in, 3: Q1.2 step from `speed_controller`.
- paused, in, 1: pause state from `speed_controller`.
- speed, out, 3: speed code to `speed_controller`.
- pause, out, 1: one-cycle pause request.
- resume, out, 1: one-cycle resume request.
- frame_tick, out, 1: one-cycle pulse when the offset advanced.
- offset, out, OFFSET_WIDTH: integer pixel offset.
- offset_frac, out, 2: fractional offset bits.

Behaviour:
- Reset (async, all outputs): speed=3'd1, pause=0, resume=0, frame_tick=0, offset=0, offset_frac=0. Also clears all sync flops, debounce counters and debounced levels.
- Synchronisers: every async input passes through a 2-flop synchroniser before any use.
- Debounce, per button:
  - Counter clears whenever the synced level equals the debounced level.
  - Otherwise the counter increments; on reaching DEBOUNCE_CYCLES-1 the debounced level flips and the counter clears.
  - A press event is a debounced 0->1 transition, one cycle wide. Releases generate nothing.
  - A button held through reset yields one press event DEBOUNCE_CYCLES after reset deassertion.
- Pause toggle: on a btn_pause event, if paused=0 assert pause for 1 cycle, else assert resume for 1 cycle. pause and resume are never high together.
- Speed:
  - faster event: speed+1, saturating at 6.
  - slower event: speed-1, saturating at 1.
  - Both events in the same cycle: speed unchanged.
  - speed is always in 1..6; 0 and 7 are never driven.
- Vsync edge: vsync_rise = synced vsync & ~previous synced vsync. The registered update lands 3 clk edges after the first edge that samples vsync high.
- Accumulator {offset, offset_frac}:
  - On vsync_rise with paused=0: sum = {offset, offset_frac} + step_size.
  - If the integer part of sum >= OFFSET_PERIOD, subtract OFFSET_PERIOD from the integer part; the fraction is preserved.
  - Max step is 1.5 px, so one subtraction always suffices. Compute in OFFSET_WIDTH+1 bits so nothing overflows before the compare.
  - frame_tick=1 in the same cycle the new offset becomes visible.
- Paused: on vsync_rise with paused=1 the offset holds and frame_tick stays 0.
- Latency interaction: `paused` is sampled as presented. A pause pulse coinciding with vsync_rise does not block that frame's advance, because `speed_controller` updates paused one cycle later.
- Reset mid-frame or mid-debounce: immediate async clear. No event or pulse is emitted for a press or edge in progress.

Decomposition:
- Package anim_pkg:
  - SPEED_MIN=3'd1, SPEED_MAX=3'd6, SPEED_RESET=3'd1.
  - FRAC_BITS=2.
  - typedef speed_t (3-bit).
- Sub-module button_debouncer (2-flop sync + counter + press-event output), parameterised by DEBOUNCE_CYCLES, instantiated three times.
- vsync uses a bare 2-flop synchroniser with no debounce.

Test Plan (DEBOUNCE_CYCLES=4, OFFSET_PERIOD=640, `speed_controller` model in loop):
- Reset then 3 vsync pulses at speed=1 -> three frame_ticks; offset=0, offset_frac=3; fourth vsync -> offset=1, offset_frac=0.
- Offset at 639.75 (offset=639, offset_frac=3), step_size=6, vsync pulse -> offset=1, offset_frac=1 (641.25-640).
- btn_faster held 10 cycles, pressed 7 times -> speed 1,2,...,6 then stays 6. btn_slower pressed 7 times -> ends at 1. Both pressed simultaneously -> unchanged.
- btn_pause press with bounce (toggles every cycle for 3 cycles, then stable) -> exactly one pause pulse. Subsequent vsyncs -> offset frozen, no frame_tick. Second press -> one resume pulse and advance resumes.
- btn_pause glitch shorter than 4 cycles -> no pause/resume pulse.
- rst asserted mid-debounce and mid-accumulate (offset=100) -> outputs at reset values immediately. Button held through reset -> single press event 4 cycles after release of rst.
